count_sched: RTL

Round-robin scheduler that shares one start/done counting engine between NREQ requesters. It arbitrates requests, issues the engine start pulse and waits for done under a watchdog. It then acknowledges the winner and pulses the engine reset to re-arm it, because the engine parks in its terminal state after done. Any engine alert, watchdog expiry or illegal state encoding forces a sticky ERROR state that raises `alert_o`.

---
 rtl/count_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin scheduler sharing one start/done engine, with watchdog and sticky error
module count_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [NREQ-1:0] ack_o,
  output logic            eng_start_o,
  input  logic            eng_done_i,
  input  logic            eng_alert_i,
  output logic            eng_rst_o,
  output logic            busy_o,
  output logic            alert_o
);
  localparam int PW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    START = 3'b001,
    WAIT  = 3'b010,
    ACK   = 3'b011,
    CLEAR = 3'b100,
    ERROR = 3'b110
  } state_t;

  // Plain vector so that the unused encodings 101/111 remain representable.
  logic [2:0]      state_q;
  state_t          state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;

  // Search from ptr upward, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && req_i[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = ERROR;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (found) begin
          state_d        = START;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
          wd_d           = '0;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        wd_d = wd_q + WW'(1);
        if (eng_alert_i)                 state_d = ERROR;
        else if (eng_done_i)             state_d = ACK;
        else if (wd_q == WW'(TIMEOUT))   state_d = ERROR;
        else                             state_d = WAIT;
      end
      ACK:     state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = ERROR;
    endcase
    // Grant drops on the same edge that enters CLEAR or ERROR.
    if (state_d == CLEAR || state_d == ERROR) gnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign ack_o       = (state_q == ACK) ? gnt_q : '0;
  assign eng_start_o = (state_q == START);
  // The engine parks after done, so it is re-armed in CLEAR and held reset in ERROR.
  assign eng_rst_o   = rst || (state_q == CLEAR) || (state_q == ERROR);
  assign busy_o      = (state_q != IDLE);
  assign alert_o     = (state_q == ERROR);

endmodule
